apple_video_line_fetch: RTL

Reader-side counterpart to the Apple II shadow-memory writer. Once per scanline it fetches 40 display columns (main + aux bytes) from the SDRAM video port into a ping-pong line buffer. The renderer reads the front buffer by column while the next line is fetched into the back buffer.

---
 rtl/apple_video_pkg.sv | 26 ++
 rtl/apple_scanline_addr.sv | 33 +++
 rtl/apple_video_line_fetch.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/apple_video_pkg.sv
// Shared types and constants for the Apple II video line fetcher.
// Build option: APPLE_FETCH_OVERRUN_CNT_EN (used by apple_video_line_fetch).
package apple_video_pkg;

    localparam logic [15:0] TEXT_BASE_P1     = 16'h0400;
    localparam logic [15:0] TEXT_BASE_P2     = 16'h0800;
    localparam logic [15:0] HIRES_BASE_P1    = 16'h2000;
    localparam logic [15:0] HIRES_BASE_P2    = 16'h4000;
    localparam logic [7:0]  MIXED_SPLIT_LINE = 8'd160;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Soft-switch snapshot taken when a scanline fetch is requested.
    typedef struct packed {
        logic text;
        logic mixed;
        logic page2;
        logic hires;
        logic store80;
    } line_mode_t;

endpackage

// File: rtl/apple_scanline_addr.sv
// Maps (scanline, soft-switch mode) to the 16-bit byte address of the
// first display byte of that scanline. Purely combinational.
module apple_scanline_addr
    import apple_video_pkg::*;
(
    input  logic [7:0]  line_i,
    input  line_mode_t  mode_i,
    output logic [15:0] base_o
);

    logic        use_text;
    logic        alt_page;
    logic [4:0]  row;
    logic [15:0] text_off;
    logic [15:0] hires_off;

    // Select text/lores or hires layout and page, then add the interleaved offset.
    always_comb begin
        row       = line_i[7:3];
        use_text  = mode_i.text || !mode_i.hires ||
                    (mode_i.mixed && (line_i >= MIXED_SPLIT_LINE));
        alt_page  = mode_i.page2 && !mode_i.store80;
        text_off  = {6'b0, row[2:0], 7'b0} + ({14'b0, row[4:3]} * 16'd40);
        hires_off = {3'b0, line_i[2:0], 10'b0} + {6'b0, line_i[5:3], 7'b0} +
                    ({14'b0, line_i[7:6]} * 16'd40);
        if (use_text) begin
            base_o = (alt_page ? TEXT_BASE_P2 : TEXT_BASE_P1) + text_off;
        end else begin
            base_o = (alt_page ? HIRES_BASE_P2 : HIRES_BASE_P1) + hires_off;
        end
    end

endmodule

// File: rtl/apple_video_line_fetch.sv
// Per-scanline fetch of main/aux display bytes from the SDRAM video port
// into a ping-pong line buffer read by the renderer.
// Build option: APPLE_FETCH_OVERRUN_CNT_EN builds a saturating overrun counter;
// without it overrun_count_o is tied to zero.
module apple_video_line_fetch
    import apple_video_pkg::*;
#(
    parameter int LINES = 192,
    parameter int COLS  = 40
) (
    input  logic        clk_logic,
    input  logic        system_reset_n,
    input  logic        line_start_i,
    input  logic [7:0]  line_i,
    input  logic        TEXT_MODE,
    input  logic        MIXED_MODE,
    input  logic        PAGE2,
    input  logic        HIRES_MODE,
    input  logic        STORE80,
    output logic        mem_rd_o,
    output logic [20:0] mem_addr_o,
    input  logic [31:0] mem_q_i,
    input  logic        mem_ack_i,
    input  logic [5:0]  rd_col_i,
    output logic [7:0]  rd_main_o,
    output logic [7:0]  rd_aux_o,
    output logic        front_valid_o,
    output logic        busy_o,
    output logic        overrun_o,
    output logic [15:0] overrun_count_o
);

    localparam logic [4:0] LAST_K  = 5'(COLS / 2 - 1);
    localparam logic [8:0] LINES_L = 9'(LINES);
    localparam logic [5:0] COLS_L  = 6'(COLS);

    fetch_state_t state_q;
    logic [4:0]   k_q;
    logic [14:0]  addr_q;
    logic [14:0]  base_word_q;
    logic         done_q;
    logic         sel_q;
    logic         front_valid_q;
    logic         overrun_q;
    logic         mem_rd_q;
    logic [15:0]  rd_q;

    line_mode_t   mode_in;
    logic [15:0]  new_base;
    logic         unused_base_lsb;
    logic         start_ok;
    logic         ovr_evt;
    logic         wr_en;

    // Each column holds {aux, main}; buffer index sel_q is the front buffer.
    logic [15:0]  buf_mem [0:1][0:COLS-1];

    assign mode_in = '{text: TEXT_MODE, mixed: MIXED_MODE, page2: PAGE2,
                       hires: HIRES_MODE, store80: STORE80};

    apple_scanline_addr u_scanline_addr (
        .line_i (line_i),
        .mode_i (mode_in),
        .base_o (new_base)
    );

    // Line bases are always even, so only the word part is kept.
    assign unused_base_lsb = new_base[0];

    assign start_ok = line_start_i && ({1'b0, line_i} < LINES_L);
    assign ovr_evt  = start_ok && (state_q != IDLE);
    assign wr_en    = (state_q == FETCH) && mem_ack_i && !start_ok;

    // Fetch sequencer: swap/launch, word stepping, overrun redirect and drain.
    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_q       <= IDLE;
            k_q           <= '0;
            addr_q        <= '0;
            base_word_q   <= '0;
            done_q        <= 1'b0;
            sel_q         <= 1'b0;
            front_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
            mem_rd_q      <= 1'b0;
        end else begin
            if (ovr_evt) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        if (done_q) begin
                            sel_q         <= ~sel_q;
                            front_valid_q <= 1'b1;
                            done_q        <= 1'b0;
                        end
                        base_word_q <= new_base[15:1];
                        addr_q      <= new_base[15:1];
                        k_q         <= '0;
                        mem_rd_q    <= 1'b1;
                        state_q     <= FETCH;
                    end
                end
                FETCH: begin
                    if (start_ok) begin
                        base_word_q <= new_base[15:1];
                        k_q         <= '0;
                        if (mem_ack_i) begin
                            addr_q <= new_base[15:1];
                        end else begin
                            state_q <= DRAIN;
                        end
                    end else if (mem_ack_i) begin
                        if (k_q == LAST_K) begin
                            done_q   <= 1'b1;
                            mem_rd_q <= 1'b0;
                            state_q  <= IDLE;
                        end else begin
                            k_q    <= k_q + 5'd1;
                            addr_q <= addr_q + 15'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (start_ok) begin
                        base_word_q <= new_base[15:1];
                        if (mem_ack_i) begin
                            addr_q  <= new_base[15:1];
                            state_q <= FETCH;
                        end
                    end else if (mem_ack_i) begin
                        addr_q  <= base_word_q;
                        state_q <= FETCH;
                    end
                end
                default: begin
                    mem_rd_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    // Back-buffer fill: one 32-bit word lands in two adjacent columns.
    always_ff @(posedge clk_logic) begin
        if (wr_en) begin
            buf_mem[~sel_q][{k_q, 1'b0}] <= mem_q_i[15:0];
            buf_mem[~sel_q][{k_q, 1'b1}] <= mem_q_i[31:16];
        end
    end

    // Registered renderer read from the front buffer; out-of-range columns read 0.
    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            rd_q <= '0;
        end else if (rd_col_i < COLS_L) begin
            rd_q <= buf_mem[sel_q][rd_col_i];
        end else begin
            rd_q <= '0;
        end
    end

`ifdef APPLE_FETCH_OVERRUN_CNT_EN
    logic [15:0] ovr_cnt_q;

    // Saturating count of overrun events, cleared only by reset.
    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            ovr_cnt_q <= '0;
        end else if (ovr_evt && (ovr_cnt_q != 16'hFFFF)) begin
            ovr_cnt_q <= ovr_cnt_q + 16'd1;
        end
    end

    assign overrun_count_o = ovr_cnt_q;
`else
    assign overrun_count_o = '0;
`endif

    assign mem_rd_o      = mem_rd_q;
    assign mem_addr_o    = {6'b0, addr_q};
    assign rd_main_o     = rd_q[7:0];
    assign rd_aux_o      = rd_q[15:8];
    assign front_valid_o = front_valid_q;
    assign busy_o        = (state_q != IDLE);
    assign overrun_o     = overrun_q;

endmodule
